trigger_surround_cache: RTL and testbench

Captures a stream of 8-bit ADC samples into a 32-entry ring buffer. When a sample reaches a threshold, it freezes a window of 16 pre-trigger and 16 post-trigger samples and records the trigger timestamp. It then streams the window out byte-by-byte on request. It sits between the ADC front end and the host-side readout logic.

---
 rtl/trigger_surround_cache.sv | 226 ++++++++++++++++++++++
 tb/tb_trigger_surround_cache.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_surround_cache.sv
// trigger_surround_cache
// Captures 8-bit ADC samples into a ring buffer. When a sample reaches
// TRIG_THRESHOLD the buffer is frozen holding PRE_SAMPLES samples before the
// trigger and POST_SAMPLES samples from the trigger onward. The trigger
// timestamp is latched, and on host request the window is streamed out
// oldest first, one byte per non-stalled cycle.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   start         in   begin sampling (IDLE only)
//   adc_data[7:0] in   ADC sample, taken every clock in RUN/POST
//   req           in   host read request (DONE only)
//   sbf           in   send-buffer-full, stalls readout while high
//   trd           out  trigger detected
//   cd            out  cache done, window frozen and awaiting req
//   rdy           out  high in IDLE and DONE
//   trigtm[31:0]  out  timer value latched at the trigger sample
//   sd            out  send done, one-cycle pulse
//   dat[7:0]      out  readout byte
//   current_state[3:0] out  state encoding for debug
module trigger_surround_cache #(
    parameter logic [7:0] TRIG_THRESHOLD = 8'd200,
    parameter int         PRE_SAMPLES    = 16,
    parameter int         POST_SAMPLES   = 16,
    parameter int         DEPTH          = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  adc_data,
    input  logic        req,
    input  logic        sbf,
    output logic        trd,
    output logic        cd,
    output logic        rdy,
    output logic [31:0] trigtm,
    output logic        sd,
    output logic [7:0]  dat,
    output logic [3:0]  current_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PRE_OFS    = AW'(PRE_SAMPLES);
    // Post counter value while the final post sample is being written.
    localparam logic [AW:0]   POST_LAST  = (AW+1)'(POST_SAMPLES - 1);
    localparam logic [AW:0]   BYTE_TOTAL = (AW+1)'(DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_RUN  = 4'd1,
        ST_POST = 4'd2,
        ST_DONE = 4'd3,
        ST_SEND = 4'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            trig_hit_s;
    logic            post_last_s;
    logic            send_end_s;

    logic [7:0]      mem_r [0:DEPTH-1];
    logic [AW-1:0]   wp_r;
    logic [AW-1:0]   rp_r;
    logic [AW-1:0]   trig_ptr_r;
    logic [AW:0]     post_cnt_r;
    logic [AW:0]     byte_cnt_r;
    logic [31:0]     timer_r;
    logic [31:0]     trigtm_r;
    logic            trd_r;
    logic            cd_r;
    logic            sd_r;
    logic [7:0]      dat_r;

    // Decode conditions that drive both the state transition and the datapath.
    always_comb begin
        trig_hit_s  = 1'b0;
        post_last_s = 1'b0;
        send_end_s  = 1'b0;
        if (adc_data >= TRIG_THRESHOLD) begin
            trig_hit_s = 1'b1;
        end else begin
            trig_hit_s = 1'b0;
        end
        if (post_cnt_r == POST_LAST) begin
            post_last_s = 1'b1;
        end else begin
            post_last_s = 1'b0;
        end
        // All bytes already handed out; this cycle only raises sd.
        if (byte_cnt_r == BYTE_TOTAL) begin
            send_end_s = 1'b1;
        end else begin
            send_end_s = 1'b0;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (trig_hit_s) begin
                    state_nxt_s = ST_POST;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_POST: begin
                if (post_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_POST;
                end
            end
            ST_DONE: begin
                if (req) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_SEND: begin
                if (send_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture buffer, pointers, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
            wp_r       <= '0;
            rp_r       <= '0;
            trig_ptr_r <= '0;
            post_cnt_r <= '0;
            byte_cnt_r <= '0;
            timer_r    <= 32'd0;
            trigtm_r   <= 32'd0;
            trd_r      <= 1'b0;
            cd_r       <= 1'b0;
            sd_r       <= 1'b0;
            dat_r      <= 8'd0;
        end else begin
            timer_r <= timer_r + 32'd1;
            sd_r    <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    mem_r[wp_r] <= adc_data;
                    wp_r        <= wp_r + AW'(1);
                    if (trig_hit_s) begin
                        trigtm_r   <= timer_r;
                        trig_ptr_r <= wp_r;
                        trd_r      <= 1'b1;
                        // The trigger sample is the first post sample.
                        post_cnt_r <= (AW+1)'(1);
                    end
                end
                ST_POST: begin
                    mem_r[wp_r] <= adc_data;
                    wp_r        <= wp_r + AW'(1);
                    post_cnt_r  <= post_cnt_r + (AW+1)'(1);
                    if (post_last_s) begin
                        cd_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (req) begin
                        cd_r       <= 1'b0;
                        // Pointer arithmetic wraps modulo DEPTH.
                        rp_r       <= trig_ptr_r - PRE_OFS;
                        byte_cnt_r <= '0;
                    end
                end
                ST_SEND: begin
                    if (send_end_s) begin
                        sd_r  <= 1'b1;
                        trd_r <= 1'b0;
                    end else if (!sbf) begin
                        dat_r      <= mem_r[rp_r];
                        rp_r       <= rp_r + AW'(1);
                        byte_cnt_r <= byte_cnt_r + (AW+1)'(1);
                    end
                end
                default: begin
                    // IDLE and unused codes: sampling and readout stopped.
                end
            endcase
        end
    end

    assign trd           = trd_r;
    assign cd            = cd_r;
    assign sd            = sd_r;
    assign dat           = dat_r;
    assign trigtm        = trigtm_r;
    assign current_state = state_r;
    assign rdy           = (state_r == ST_IDLE) || (state_r == ST_DONE);

endmodule

// File: tb/tb_trigger_surround_cache.sv
// Directed self-checking bench for trigger_surround_cache.
module tb_trigger_surround_cache;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  adc_data;
    logic        req;
    logic        sbf;
    logic        trd;
    logic        cd;
    logic        rdy;
    logic [31:0] trigtm;
    logic        sd;
    logic [7:0]  dat;
    logic [3:0]  current_state;

    int pass_cnt;
    int total_cnt;

    logic [31:0] exp_timer;
    logic [31:0] exp_trig;
    logic [7:0]  exp_win [32];
    logic [7:0]  got_win [32];

    trigger_surround_cache dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .adc_data      (adc_data),
        .req           (req),
        .sbf           (sbf),
        .trd           (trd),
        .cd            (cd),
        .rdy           (rdy),
        .trigtm        (trigtm),
        .sd            (sd),
        .dat           (dat),
        .current_state (current_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference free-running timer.
    always @(posedge clk) begin
        if (reset) exp_timer <= 32'd0;
        else       exp_timer <= exp_timer + 32'd1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; req = 1'b0; sbf = 1'b0; adc_data = 8'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Drive samples until DONE: n_pre of pre_val, a trigger sample, then 15 posts.
    task automatic capture(input int n_pre, input logic [7:0] pre_val,
                           input logic [7:0] trig_val, input logic [7:0] post_val);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n_pre; i++) begin
            adc_data = pre_val;
            tick();
        end
        adc_data = trig_val;
        exp_trig = exp_timer;
        tick();
        for (int i = 0; i < 15; i++) begin
            adc_data = post_val;
            tick();
        end
        adc_data = 8'd0;
    endtask

    // Issue req and collect bytes; sbf held high for stall_len cycles from stall_at.
    task automatic read_window(input int stall_at, input int stall_len,
                               output int n_bytes, output int sd_cyc,
                               output int hold_err, output logic [3:0] st_send);
        logic [7:0] last;
        n_bytes = 0; sd_cyc = -1; hold_err = 0;
        req = 1'b1; sbf = 1'b0;
        tick();
        req = 1'b0;
        st_send = current_state;
        last = dat;
        for (int c = 0; c < 100; c++) begin
            sbf = (c >= stall_at) && (c < stall_at + stall_len);
            tick();
            if (sd === 1'b1) begin
                sd_cyc = c;
                break;
            end else if (!sbf) begin
                if (n_bytes < 32) got_win[n_bytes] = dat;
                n_bytes++;
                last = dat;
            end else if (dat !== last) begin
                hold_err++;
            end
        end
        sbf = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        total_cnt++; if (current_state !== 4'd0) $display("FAIL reset_state got %0d want 0", current_state); else pass_cnt++;
        total_cnt++; if ({trd, cd, sd} !== 3'b000) $display("FAIL reset_flags got %b want 000", {trd, cd, sd}); else pass_cnt++;
        total_cnt++; if (rdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", rdy); else pass_cnt++;
        total_cnt++; if (trigtm !== 32'd0 || dat !== 8'd0) $display("FAIL reset_data got trigtm=%0d dat=%0d want 0 0", trigtm, dat); else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (current_state !== 4'd1) $display("FAIL start_run got %0d want 1", current_state); else pass_cnt++;
        total_cnt++; if (rdy !== 1'b0) $display("FAIL run_rdy got %b want 0", rdy); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if (current_state !== 4'd0) $display("FAIL midreset_state got %0d want 0", current_state); else pass_cnt++;
        total_cnt++; if ({trd, cd, sd, rdy} !== 4'b0001 || trigtm !== 32'd0) $display("FAIL midreset_out got trd/cd/sd/rdy=%b trigtm=%0d want 0001 0", {trd, cd, sd, rdy}, trigtm); else pass_cnt++;
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        total_cnt++; if (current_state !== 4'd0) $display("FAIL reset_start got %0d want 0", current_state); else pass_cnt++;
        req = 1'b1; sbf = 1'b1;
        tick();
        req = 1'b0; sbf = 1'b0;
        total_cnt++; if (current_state !== 4'd0) $display("FAIL idle_req got %0d want 0", current_state); else pass_cnt++;
    endtask

    task automatic test_no_trigger;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            adc_data = 8'(i);
            tick();
        end
        adc_data = 8'd199;
        req = 1'b1;
        tick();
        req = 1'b0;
        adc_data = 8'd50;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++; if (current_state !== 4'd1) $display("FAIL notrig_state got %0d want 1", current_state); else pass_cnt++;
        total_cnt++; if ({rdy, cd, trd} !== 3'b000) $display("FAIL notrig_flags got rdy/cd/trd=%b want 000", {rdy, cd, trd}); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if (current_state !== 4'd0) $display("FAIL notrig_reset got %0d want 0", current_state); else pass_cnt++;
    endtask

    task automatic test_trigger;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            adc_data = 8'd10;
            tick();
        end
        adc_data = 8'd200;
        exp_trig = exp_timer;
        tick();
        total_cnt++; if (trd !== 1'b1 || current_state !== 4'd2) $display("FAIL trig_edge got trd=%b state=%0d want 1 2", trd, current_state); else pass_cnt++;
        total_cnt++; if (trigtm !== exp_trig) $display("FAIL trig_time got %0d want %0d", trigtm, exp_trig); else pass_cnt++;
        for (int i = 0; i < 14; i++) begin
            adc_data = 8'd20;
            tick();
        end
        total_cnt++; if (current_state !== 4'd2 || cd !== 1'b0) $display("FAIL post14 got state=%0d cd=%b want 2 0", current_state, cd); else pass_cnt++;
        tick();
        adc_data = 8'd0;
        total_cnt++; if (current_state !== 4'd3 || cd !== 1'b1 || rdy !== 1'b1) $display("FAIL done got state=%0d cd=%b rdy=%b want 3 1 1", current_state, cd, rdy); else pass_cnt++;
        start = 1'b1; adc_data = 8'd250;
        tick();
        start = 1'b0; adc_data = 8'd0;
        total_cnt++; if (current_state !== 4'd3 || trd !== 1'b1 || trigtm !== exp_trig) $display("FAIL done_hold got state=%0d trd=%b trigtm=%0d want 3 1 %0d", current_state, trd, trigtm, exp_trig); else pass_cnt++;
    endtask

    // Shared by readout scenarios; name identifies the scenario in FAIL lines.
    task automatic check_readout(input string name, input int stall_at, input int stall_len);
        int n, sdc, herr;
        logic [3:0] st;
        int bad;
        read_window(stall_at, stall_len, n, sdc, herr, st);
        total_cnt++; if (st !== 4'd4 || cd !== 1'b0) $display("FAIL %s_send got state=%0d cd=%b want 4 0", name, st, cd); else pass_cnt++;
        total_cnt++; if (n !== 32) $display("FAIL %s_count got %0d want 32", name, n); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (got_win[i] !== exp_win[i]) begin
                if (bad == 0) $display("FAIL %s_byte%0d got %0d want %0d", name, i, got_win[i], exp_win[i]);
                bad++;
            end
        end
        total_cnt++; if (bad != 0) $display("FAIL %s_bytes got %0d wrong want 0", name, bad); else pass_cnt++;
        total_cnt++; if (herr != 0) $display("FAIL %s_hold got %0d changes want 0", name, herr); else pass_cnt++;
        total_cnt++; if (sdc !== 32 + stall_len) $display("FAIL %s_sd_cycle got %0d want %0d", name, sdc, 32 + stall_len); else pass_cnt++;
        total_cnt++; if (current_state !== 4'd0 || trd !== 1'b0 || rdy !== 1'b1) $display("FAIL %s_end got state=%0d trd=%b rdy=%b want 0 0 1", name, current_state, trd, rdy); else pass_cnt++;
        tick();
        total_cnt++; if (sd !== 1'b0) $display("FAIL %s_sd_pulse got %b want 0", name, sd); else pass_cnt++;
    endtask

    task automatic test_readout;
        for (int i = 0; i < 16; i++) exp_win[i] = 8'd10;
        exp_win[16] = 8'd200;
        for (int i = 17; i < 32; i++) exp_win[i] = 8'd20;
        check_readout("read", 1000, 0);
    endtask

    task automatic test_stall;
        do_reset();
        capture(40, 8'd10, 8'd200, 8'd20);
        total_cnt++; if (current_state !== 4'd3) $display("FAIL stall_done got %0d want 3", current_state); else pass_cnt++;
        check_readout("stall", 10, 5);
    endtask

    task automatic test_early_trigger;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        adc_data = 8'd5;
        tick();
        adc_data = 8'd6;
        tick();
        adc_data = 8'd255;
        exp_trig = exp_timer;
        tick();
        total_cnt++; if (trd !== 1'b1 || trigtm !== exp_trig) $display("FAIL early_trig got trd=%b trigtm=%0d want 1 %0d", trd, trigtm, exp_trig); else pass_cnt++;
        for (int i = 0; i < 15; i++) begin
            adc_data = 8'(30 + i);
            tick();
        end
        adc_data = 8'd0;
        total_cnt++; if (current_state !== 4'd3) $display("FAIL early_done got %0d want 3", current_state); else pass_cnt++;
        for (int i = 0; i < 14; i++) exp_win[i] = 8'd0;
        exp_win[14] = 8'd5;
        exp_win[15] = 8'd6;
        exp_win[16] = 8'd255;
        for (int i = 0; i < 15; i++) exp_win[17 + i] = 8'(30 + i);
        check_readout("early", 1000, 0);
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset = 1'b1; start = 1'b0; req = 1'b0; sbf = 1'b0; adc_data = 8'd0;
        exp_trig = 32'd0;
        test_reset();
        test_no_trigger();
        test_trigger();
        test_readout();
        test_stall();
        test_early_trigger();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
